// File: rtl/uart_rx_if.sv
// uart_rx_if: received-byte bundle from uart_rx to its consumer.
// Carries the byte, the completion pulse, the per-frame error flags and the busy status.
`default_nettype none

interface uart_rx_if;
    logic [7:0] data_o;
    logic       valid_o;
    logic       parity_err_o;
    logic       crc_err_o;
    logic       frame_err_o;
    logic       busy_o;

    modport master (
        output data_o, valid_o, parity_err_o, crc_err_o, frame_err_o, busy_o
    );

    modport slave (
        input  data_o, valid_o, parity_err_o, crc_err_o, frame_err_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with even parity, optional CRC-8 byte and stop-bit check.
// Reports each completed frame with a one-cycle valid pulse and registered error flags.
`default_nettype none

module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    input  wire logic  rx_i,
    input  wire logic  sample_tick_i,
    input  wire logic  crc_en_i,
    uart_rx_if.master  out_if
);

    localparam int             TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]  HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]  FULL_M1 = TW'(OVERSAMPLE - 1);
    localparam logic [7:0]     POLY    = 8'h07;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_CRC    = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t          state_q;
    logic            sync1_q, sync2_q, prev_q;
    logic [TW-1:0]   tcnt_q;
    logic [2:0]      bcnt_q;
    logic [7:0]      shreg_q, crc_q, cmp_q;
    logic            crc_en_q, par_acc_q, crc_acc_q;
    logic [7:0]      data_q;
    logic            valid_q, par_err_q, crc_err_q, frame_err_q, busy_q;

    logic            line, fall, sample_now, fb;
    logic [7:0]      shreg_d, crc_d, cmp_d;

    always_comb begin
        line       = sync2_q;
        fall       = prev_q & ~sync2_q;
        sample_now = 1'b0;
        if (state_q != S_IDLE && sample_tick_i)
            sample_now = (tcnt_q == ((state_q == S_START) ? HALF_M1 : FULL_M1));
        shreg_d = {line, shreg_q[7:1]};
        fb      = crc_q[7] ^ line;
        crc_d   = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
        cmp_d   = {cmp_q[6:0], line};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            crc_q       <= '0;
            cmp_q       <= '0;
            crc_en_q    <= 1'b0;
            par_acc_q   <= 1'b0;
            crc_acc_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;

            // Every sample point restarts the count, so the next bit centre is OVERSAMPLE ticks later.
            if (state_q != S_IDLE && sample_tick_i)
                tcnt_q <= sample_now ? '0 : tcnt_q + 1'b1;

            case (state_q)
                S_IDLE: begin
                    tcnt_q <= '0;
                    if (fall) begin
                        state_q   <= S_START;
                        busy_q    <= 1'b1;
                        crc_en_q  <= crc_en_i;
                        crc_q     <= '0;
                        bcnt_q    <= '0;
                        crc_acc_q <= 1'b0;
                    end
                end
                S_START: begin
                    if (sample_now) begin
                        if (!line) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_now) begin
                        shreg_q <= shreg_d;
                        crc_q   <= crc_d;
                        bcnt_q  <= bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7)
                            state_q <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (sample_now) begin
                        par_acc_q <= (line != ^shreg_q);
                        bcnt_q    <= '0;
                        state_q   <= crc_en_q ? S_CRC : S_STOP;
                    end
                end
                S_CRC: begin
                    if (sample_now) begin
                        cmp_q  <= cmp_d;
                        bcnt_q <= bcnt_q + 3'd1;
                        if (bcnt_q == 3'd7) begin
                            crc_acc_q <= (cmp_d != crc_q);
                            state_q   <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (sample_now) begin
                        data_q      <= shreg_q;
                        par_err_q   <= par_acc_q;
                        crc_err_q   <= crc_acc_q;
                        frame_err_q <= ~line;
                        valid_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_if.data_o       = data_q;
    assign out_if.valid_o      = valid_q;
    assign out_if.parity_err_o = par_err_q;
    assign out_if.crc_err_o    = crc_err_q;
    assign out_if.frame_err_o  = frame_err_q;
    assign out_if.busy_o       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames for uart_rx, checked by a queue-based scoreboard.
// The reference model derives flags from bit counts and CRC-8 polynomial long division.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

    localparam int OS = 16;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic rx     = 1'b1;
    logic tick   = 1'b0;
    logic crc_en = 1'b0;

    uart_rx_if bus();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .rx_i          (rx),
        .sample_tick_i (tick),
        .crc_en_i      (crc_en),
        .out_if        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       cerr;
        logic       ferr;
    } exp_t;

    exp_t    exp_q[$];
    longint  valid_t[$];
    int      tests = 0;
    int      fails = 0;
    int      div   = 1;
    longint  cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            if (div <= 1) begin
                tick = 1'b1;
            end else begin
                tick = (c == 0);
                c = (c + 1) % div;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // CRC-8 (x^8+x^2+x+1) as remainder of M(x)*x^8, bits in line order (data LSB first).
    function automatic logic [7:0] ref_crc(input logic [7:0] d);
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) m[15-i] = d[i];
        for (int i = 15; i >= 8; i--)
            if (m[i]) m = m ^ (16'h0107 << (i - 8));
        return m[7:0];
    endfunction

    task automatic hold_bit(input logic v);
        rx = v;
        repeat (OS * div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic ce,
                              input logic [7:0] crc, input logic stop, input int gap);
        exp_t e;
        e.data = d;
        e.perr = (par != ($countones(d) % 2 == 1));
        e.cerr = ce ? (crc != ref_crc(d)) : 1'b0;
        e.ferr = ~stop;
        exp_q.push_back(e);
        crc_en = ce;
        hold_bit(1'b0);
        crc_en = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        hold_bit(par);
        if (ce) for (int i = 7; i >= 0; i--) hold_bit(crc[i]);
        hold_bit(stop);
        repeat (gap) hold_bit(1'b1);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  bus.data_o, 8'h00);
        check({tag, "_valid"}, bus.valid_o, 0);
        check({tag, "_perr"},  bus.parity_err_o, 0);
        check({tag, "_cerr"},  bus.crc_err_o, 0);
        check({tag, "_ferr"},  bus.frame_err_o, 0);
        check({tag, "_busy"},  bus.busy_o, 0);
    endtask

    // Monitor: pops the scoreboard on every valid pulse.
    initial begin
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.valid_o) begin
                valid_t.push_back(cyc);
                check("valid_width", prev_valid, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data",       bus.data_o,       e.data);
                    check("parity_err", bus.parity_err_o, e.perr);
                    check("crc_err",    bus.crc_err_o,    e.cerr);
                    check("frame_err",  bus.frame_err_o,  e.ferr);
                end
            end
            prev_valid = bus.valid_o;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n0;
        logic [7:0]  d, crc;
        logic        ce, par, stop;
        int          gap;

        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, 1);
        send_frame(8'h01, 1'b1, 1'b1, 8'h89, 1'b1, 1);
        send_frame(8'h01, 1'b1, 1'b1, 8'h88, 1'b1, 1);
        send_frame(8'h03, 1'b1, 1'b0, 8'h00, 1'b1, 1);

        // Stop bit low, then the line stays low: no retrigger.
        send_frame(8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 0);
        repeat (3) hold_bit(1'b0);
        check("break_busy", bus.busy_o, 0);
        repeat (2) hold_bit(1'b1);
        wait_drain(100);

        // Short glitch: false start.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy", bus.busy_o, 0);
        send_frame(8'h5A, 1'b0, 1'b0, 8'h00, 1'b1, 1);
        wait_drain(100);

        // Reset in the middle of the data bits.
        crc_en = 1'b0;
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) hold_bit(1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1);
        wait_drain(100);

        // Back-to-back frames, no idle gap.
        n0 = valid_t.size();
        send_frame(8'h12, 1'b0, 1'b0, 8'h00, 1'b1, 0);
        send_frame(8'h34, 1'b1, 1'b0, 8'h00, 1'b1, 1);
        wait_drain(100);
        check("b2b_count", valid_t.size() - n0, 2);
        if (valid_t.size() >= n0 + 2)
            check("b2b_spacing", 32'(valid_t[n0+1] - valid_t[n0]), OS * 11);

        // Randomized frames, first with tick tied high, then with a divided tick.
        for (int k = 0; k < 30; k++) begin
            if (k == 20) begin
                wait_drain(2000);
                repeat (2) hold_bit(1'b1);
                div = 3;
                repeat (2) hold_bit(1'b1);
            end
            d    = 8'($urandom);
            ce   = 1'($urandom_range(0, 1));
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            crc  = ref_crc(d) ^ (($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            send_frame(d, par, ce, crc, stop, gap);
        end
        wait_drain(4000);
        repeat (2) hold_bit(1'b1);
        check("final_busy", bus.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial receiver on the far end of the UART link: it consumes the line driven by the transmitter and reconstructs each frame. Each frame is a start bit, 8 data bits sent LSB first, an even parity bit, an optional CRC-8 byte and a stop bit. The block oversamples the line on a tick from the baud generator and checks parity, CRC and stop bit. It presents the byte with a one-cycle valid pulse and per-frame error flags to the consumer.

## Interface
- OVERSAMPLE, 16: sample ticks per bit period; even, >= 4.
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-low.
- rx_i  in  1  serial line, asynchronous to clk_i, idle high.
- sample_tick_i  in  1  one-cycle pulse, OVERSAMPLE pulses per bit period.
- crc_en_i  in  1  frame carries a CRC byte between parity and stop.
- data_o  out  8  last received byte; held until the next valid_o.
- valid_o  out  1  one-cycle pulse when a frame completes (with or without errors).
- parity_err_o  out  1  parity mismatch of the last frame; updates with valid_o.
- crc_err_o  out  1  CRC mismatch of the last frame; 0 when CRC disabled; updates with valid_o.
- frame_err_o  out  1  stop bit sampled low; updates with valid_o.
- busy_o  out  1  high from start detection until the cycle valid_o pulses.

## Operation
- rx_i passes through a 2-flop synchronizer (both flops reset to 1) before any use; a third flop holds the previous synchronized value for edge detection.
- Tick counter tcnt counts sample_tick_i pulses, width $clog2(OVERSAMPLE), and clears on every state change.
- States are IDLE, START, DATA, PARITY, CRC and STOP.
- IDLE: a synchronized falling edge (prev 1, now 0) moves to START.
  - crc_en_i is latched here and used for the whole frame; later changes are ignored.
  - The CRC register and bit counter clear here.
  - A line held low (break) does not retrigger, because a new frame needs a fresh falling edge.
- START: on tick number OVERSAMPLE/2, the line is sampled.
  - If it is still 0, go to DATA; this sample point becomes the bit centre.
  - If it is 1, this is a false start: go to IDLE with no valid_o.
- DATA: every OVERSAMPLE ticks, sample one bit into data shift register bit 7 while shifting right, so data arrives LSB first.
  - Each data bit b also updates the CRC: fb = crc[7]^b; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00). The CRC starts at 8'h00.
  - After the 8th bit, go to PARITY.
- PARITY: sample one bit. parity error = sampled bit != ^data.
  - Next state is CRC if the latched crc_en is 1, else STOP.
- CRC: sample 8 bits, MSB first, into a compare register.
  - crc error = compare register != computed CRC.
  - After 8 bits, go to STOP.
- STOP: sample one bit; frame error = (sample == 0).
  - Load data_o and the three error flags, pulse valid_o, go to IDLE.
- Parity and CRC errors do not abort the frame; the whole frame is always received.

## Timing
- Reset values: data_o = 8'h00, valid_o = 0, all error flags = 0, busy_o = 0, state = IDLE, synchronizer flops = 1.
- Reset asserted mid-frame returns to IDLE at once with no valid_o. After release, a falling edge is needed to start a new frame.
- Synchronizer latency is 2 clk_i cycles from rx_i to the internal line.
- Samples are taken in the cycle sample_tick_i completes the required count, with the state transition in the same cycle.
- The START to STOP sample spacing is exactly OVERSAMPLE ticks.
- valid_o is registered: it is high exactly one cycle, the cycle after the stop-bit sample. busy_o falls in that same cycle.
- A falling edge in the cycle valid_o is high is detected (IDLE is already active), so back-to-back frames with a 1-bit stop are supported.
- sample_tick_i may be tied high; the bit period is then OVERSAMPLE clk_i cycles.
- Frame length is 11 bits without CRC and 19 bits with CRC.

## Test plan
- sample_tick_i = 1, crc_en_i = 0, send 0xA5 with parity 0 and stop 1:
  - data_o = 0xA5, valid_o exactly one cycle, all error flags 0.
- crc_en_i = 1, send 0x01, parity 1, CRC 0x89, stop 1:
  - data_o = 0x01, crc_err_o = 0.
  - Repeat with CRC 0x88: crc_err_o = 1, data_o still 0x01.
- Send 0x03 with parity 1:
  - parity_err_o = 1, valid_o pulses.
  - Send 0x3C with a stop bit of 0: frame_err_o = 1, and no second frame starts while the line stays low.
- Glitch rx_i low for 4 cycles (less than OVERSAMPLE/2):
  - no valid_o, busy_o returns to 0, and the next good frame 0x5A is received cleanly.
- Assert rst_i low in the middle of the data bits:
  - outputs return to reset values, no valid_o; a following frame 0xFF is received correctly.
- Send two frames 0x12 and 0x34 back to back with no idle gap:
  - two valid_o pulses, OVERSAMPLE × 11 cycles apart, with data 0x12 then 0x34.
